// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI slave shifter.
// The FSM only needs to tell idle apart from an active frame.
package spi_pkg;

  localparam int unsigned SPI_DATA_W      = 8;
  localparam int unsigned SPI_SYNC_STAGES = 2;

  typedef enum logic [0:0] {
    IDLE,
    SHIFT
  } spi_slv_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer followed by a registered edge detector.
// level, rise and fall all change in the same cycle, one clk after the last sync stage.
module spi_sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              sync_out;
  logic              level_q;
  logic              rise_q;
  logic              fall_q;

  assign sync_out = sync_q[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {STAGES{RESET_VAL}};
      level_q <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      // Truncating cast drops the oldest bit and also works for a single stage.
      sync_q  <= STAGES'({sync_q, d});
      level_q <= sync_out;
      rise_q  <= sync_out & ~level_q;
      fall_q  <= ~sync_out & level_q;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI slave endpoint: oversamples SCK/SS_n/MOSI on clk, shifts frames in both directions
// and buffers one transmit byte in a valid/ready holding register.
module spi_slave_shifter
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = SPI_DATA_W,
  parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsbfe,
  input  logic              sck_in,
  input  logic              ss_n_in,
  input  logic              mosi_in,
  output logic              miso_out,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int unsigned       CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  logic sck_level, sck_rise, sck_fall;
  logic ss_level, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  spi_sync_edge #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b0)
  ) u_sck_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sck_in),
    .level(sck_level),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_sync_edge #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_ss_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ss_n_in),
    .level(ss_level),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= SYNC_STAGES'({mosi_sync_q, mosi_in});
    end
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Leading edge: SCK has just moved away from its idle level.
  logic sck_edge, lead_edge, trail_edge, sample_edge, shift_edge;

  assign sck_edge    = sck_rise | sck_fall;
  assign lead_edge   = sck_edge & (sck_level != cpol);
  assign trail_edge  = sck_edge & (sck_level == cpol);
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;

  spi_slv_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] tx_sreg_q, tx_sreg_d;
  logic [DATA_W-1:0] rx_sreg_q, rx_sreg_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              miso_q, miso_d;
  logic              rx_valid_q, rx_valid_d;
  logic              underrun_q, underrun_d;
  logic              load;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] rx_next;

  // Loads always see the pre-write holding register content.
  assign load_val = hold_full_q ? hold_q : '0;
  assign rx_next  = lsbfe ? {mosi_s, rx_sreg_q[DATA_W-1:1]} : {rx_sreg_q[DATA_W-2:0], mosi_s};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_sreg_d   = tx_sreg_q;
    rx_sreg_d   = rx_sreg_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    miso_d      = miso_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    underrun_d  = underrun_q;
    load        = 1'b0;

    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (ss_fall) begin
          load      = 1'b1;
          rx_sreg_d = '0;
          state_d   = SHIFT;
          // With cpha=0 the master samples on the first leading edge, so bit 0 goes out now.
          if (!cpha) begin
            miso_d    = first_bit(load_val, lsbfe);
            tx_sreg_d = shift_out(load_val, lsbfe);
          end else begin
            tx_sreg_d = load_val;
          end
        end
      end

      SHIFT: begin
        if (ss_rise) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (sample_edge) begin
          rx_sreg_d = rx_next;
          if (cnt_q == LAST_BIT) begin
            cnt_d      = '0;
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            load       = 1'b1;
            // Left unshifted: the next shift edge presents bit 0 of the new frame.
            tx_sreg_d  = load_val;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (shift_edge) begin
          miso_d    = first_bit(tx_sreg_q, lsbfe);
          tx_sreg_d = shift_out(tx_sreg_q, lsbfe);
        end
      end

      default: state_d = IDLE;
    endcase

    if (load) begin
      if (hold_full_q) begin
        hold_full_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tx_sreg_q   <= '0;
      rx_sreg_q   <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_sreg_q   <= tx_sreg_d;
      rx_sreg_q   <= rx_sreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      miso_q      <= miso_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      underrun_q  <= underrun_d;
    end
  end

  assign miso_out    = miso_q;
  assign miso_oe     = ~ss_level;
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign busy        = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Bench for spi_slave_shifter: a bit-banged SPI master drives the slave, received frames
// go through a scoreboard queue and MISO bytes are rebuilt by the master model.
module tb_spi_slave_shifter;

  localparam int unsigned HALF = 8;  // SCK half period in clk cycles

  logic       clk;
  logic       rst_n;
  logic       cpol, cpha, lsbfe;
  logic       sck_in, ss_n_in, mosi_in;
  logic       miso_out, miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, tx_underrun, busy;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic       rxv_prev = 1'b0;

  spi_slave_shifter #(
    .DATA_W     (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpol       (cpol),
    .cpha       (cpha),
    .lsbfe      (lsbfe),
    .sck_in     (sck_in),
    .ss_n_in    (ss_n_in),
    .mosi_in    (mosi_in),
    .miso_out   (miso_out),
    .miso_oe    (miso_oe),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_underrun(tx_underrun),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every rx_valid pops the oldest expected frame.
  always @(negedge clk) begin
    if (rx_valid) begin
      if (exp_q.size() == 0) check_eq("rx_unexpected", 32'(exp_q.size()), 32'd1);
      else check_eq("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      check_eq("rx_pulse_width", 32'(rxv_prev), 32'd0);
    end
    rxv_prev = rx_valid;
  end

  task automatic half();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic set_mode(input logic p, input logic h, input logic l);
    @(negedge clk);
    cpol   = p;
    cpha   = h;
    lsbfe  = l;
    sck_in = p;
    repeat (10) @(negedge clk);
  endtask

  task automatic write_tx(input logic [7:0] v);
    int i;
    for (i = 0; i < 50 && !tx_ready; i++) @(negedge clk);
    if (!tx_ready) check_eq("tx_ready_timeout", 32'(tx_ready), 32'd1);
    tx_data  = v;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic ss_low();
    ss_n_in = 1'b0;
    half();
  endtask

  task automatic ss_high();
    half();
    ss_n_in = 1'b1;
    half();
  endtask

  // Master side of nbits bit-times; MISO is sampled on the master's sample edge.
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      int b;
      b = lsbfe ? i : 7 - i;
      if (!cpha) begin
        mosi_in = mo[b];
        half();
        sck_in = ~cpol;
        mi[b]  = miso_out;
        half();
        sck_in = cpol;
      end else begin
        sck_in  = ~cpol;
        mosi_in = mo[b];
        half();
        sck_in = cpol;
        mi[b]  = miso_out;
        half();
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] mi, mi2;
    rst_n    = 1'b0;
    cpol     = 1'b0;
    cpha     = 1'b0;
    lsbfe    = 1'b0;
    sck_in   = 1'b0;
    ss_n_in  = 1'b1;
    mosi_in  = 1'b0;
    tx_data  = '0;
    tx_valid = 1'b0;
    repeat (4) @(negedge clk);

    check_eq("rst_miso", 32'(miso_out), 32'd0);
    check_eq("rst_miso_oe", 32'(miso_oe), 32'd0);
    check_eq("rst_tx_ready", 32'(tx_ready), 32'd1);
    check_eq("rst_rx_data", 32'(rx_data), 32'd0);
    check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_underrun", 32'(tx_underrun), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Mode 0, MSB first
    write_tx(8'hA5);
    check_eq("m0_tx_ready_full", 32'(tx_ready), 32'd0);
    exp_q.push_back(8'h3C);
    ss_low();
    check_eq("m0_tx_ready_loaded", 32'(tx_ready), 32'd1);
    check_eq("m0_busy", 32'(busy), 32'd1);
    check_eq("m0_miso_oe", 32'(miso_oe), 32'd1);
    check_eq("m0_underrun_pre", 32'(tx_underrun), 32'd0);
    xfer(8'h3C, 8, mi);
    ss_high();
    check_eq("m0_miso", 32'(mi), 32'hA5);
    drain();
    // The end-of-frame reload found the holding register empty.
    check_eq("m0_underrun_post", 32'(tx_underrun), 32'd1);
    check_eq("m0_busy_idle", 32'(busy), 32'd0);

    // Modes 1..3, LSB first
    for (int m = 1; m < 4; m++) begin
      logic [1:0] mode;
      mode = 2'(m);
      set_mode(mode[1], mode[0], 1'b1);
      write_tx(8'h81);
      exp_q.push_back(8'h0F);
      ss_low();
      xfer(8'h0F, 8, mi);
      ss_high();
      check_eq($sformatf("mode%0d_miso", m), 32'(mi), 32'h81);
      drain();
    end

    // Underrun at SS fall
    set_mode(1'b0, 1'b0, 1'b0);
    check_eq("ur_tx_ready", 32'(tx_ready), 32'd1);
    exp_q.push_back(8'h42);
    ss_low();
    xfer(8'h42, 8, mi);
    ss_high();
    check_eq("ur_miso", 32'(mi), 32'h00);
    check_eq("ur_flag", 32'(tx_underrun), 32'd1);
    drain();

    // Abort after 5 bits, then a clean frame
    write_tx(8'h77);
    ss_low();
    xfer(8'hFF, 5, mi);
    ss_high();
    repeat (10) @(negedge clk);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_tx_ready", 32'(tx_ready), 32'd1);
    write_tx(8'h99);
    exp_q.push_back(8'hE7);
    ss_low();
    xfer(8'hE7, 8, mi);
    ss_high();
    check_eq("post_abort_miso", 32'(mi), 32'h99);
    drain();

    // Reset mid-frame with a byte held and rx_data non-zero
    write_tx(8'h5A);
    ss_low();
    write_tx(8'h66);
    check_eq("mr_tx_ready_full", 32'(tx_ready), 32'd0);
    xfer(8'h03, 3, mi);
    rst_n = 1'b0;
    #1;
    check_eq("mr_miso", 32'(miso_out), 32'd0);
    check_eq("mr_miso_oe", 32'(miso_oe), 32'd0);
    check_eq("mr_tx_ready", 32'(tx_ready), 32'd1);
    check_eq("mr_rx_data", 32'(rx_data), 32'd0);
    check_eq("mr_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("mr_underrun", 32'(tx_underrun), 32'd0);
    check_eq("mr_busy", 32'(busy), 32'd0);
    @(negedge clk);
    ss_n_in = 1'b1;
    sck_in  = cpol;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Back-to-back frames under continuous SS
    write_tx(8'h11);
    ss_low();
    write_tx(8'h22);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hC3);
    xfer(8'h5A, 8, mi);
    check_eq("b2b_underrun_mid", 32'(tx_underrun), 32'd0);
    xfer(8'hC3, 8, mi2);
    ss_high();
    check_eq("b2b_miso1", 32'(mi), 32'h11);
    check_eq("b2b_miso2", 32'(mi2), 32'h22);
    drain();
    check_eq("b2b_underrun_end", 32'(tx_underrun), 32'd1);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
